control_sequencer: RTL and testbench

- Upstream controller for the basic-computer datapath; the datapath consumes its strobes (o_fetch, o_execute, o_is_ind/o_is_dir, opcode and micro-op strobes).
- Fetches a 16-bit instruction word, decodes opcode, I bit and register-reference bits, resolves indirection, then drives execute strobes.
- Holds each strobe until the datapath returns i_ex_done.
- Sequences multiple register-reference micro-ops one per execute step.

---
 rtl/cpu_pkg.sv | 47 ++++
 rtl/ctrl_decode.sv | 49 ++++
 rtl/control_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_control_sequencer.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the basic-computer control sequencer: opcodes,
// register-reference bit positions, FSM states and the micro-op priority pick.
package cpu_pkg;

    localparam int DWIDTH = 16;
    localparam int AWIDTH = 12;
    localparam int MASK_W = 7;

    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    localparam int BIT_CLA = 11;
    localparam int BIT_CLE = 10;
    localparam int BIT_CMA = 9;
    localparam int BIT_LDI = 8;
    localparam int BIT_CIR = 7;
    localparam int BIT_CIL = 6;
    localparam int BIT_INC = 5;
    localparam int BIT_HLT = 0;

    typedef enum logic [2:0] {
        S_INIT     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_INDIRECT = 3'd3,
        S_EXEC     = 3'd4,
        S_HALT     = 3'd5
    } state_t;

    // Mask bit 6 is CLA, so the highest set bit is the next micro-op to issue.
    function automatic logic [MASK_W-1:0] top_bit(input logic [MASK_W-1:0] m);
        top_bit = {MASK_W{1'b0}};
        for (int i = 0; i < MASK_W; i++) begin
            if (m[i]) begin
                top_bit    = {MASK_W{1'b0}};
                top_bit[i] = 1'b1;
            end else begin
                top_bit = top_bit;
            end
        end
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction decoder: classifies the word and extracts the
// opcode one-hot and register-reference micro-op mask.
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [DWIDTH-1:0] i_instr,
    output logic              o_is_mem_ref,
    output logic              o_is_reg_ref,
    output logic              o_is_ind,
    output logic [4:0]        o_op_onehot,
    output logic [MASK_W-1:0] o_reg_mask,
    output logic              o_hlt,
    output logic              o_illegal
);

    logic [2:0] w_op;
    logic       w_rsvd;
    logic       w_no_supp;

    // Field extraction and classification
    always_comb begin
        w_op         = i_instr[14:12];
        o_op_onehot  = 5'b00000;
        o_is_mem_ref = 1'b1;
        case (w_op)
            OP_ADD:  o_op_onehot = 5'b00001;
            OP_LDA:  o_op_onehot = 5'b00010;
            OP_STA:  o_op_onehot = 5'b00100;
            OP_BUN:  o_op_onehot = 5'b01000;
            OP_ISZ:  o_op_onehot = 5'b10000;
            default: o_is_mem_ref = 1'b0;
        endcase
        o_is_reg_ref = (w_op == OP_REG) && !i_instr[15];
        o_is_ind     = o_is_mem_ref && i_instr[15];
        if (o_is_reg_ref) begin
            o_reg_mask = {i_instr[BIT_CLA], i_instr[BIT_CLE], i_instr[BIT_CMA], i_instr[BIT_LDI],
                          i_instr[BIT_CIR], i_instr[BIT_CIL], i_instr[BIT_INC]};
            o_hlt      = i_instr[BIT_HLT];
        end else begin
            o_reg_mask = {MASK_W{1'b0}};
            o_hlt      = 1'b0;
        end
        // A register-reference word with nothing supported is either reserved bits or empty.
        w_rsvd    = |i_instr[4:1];
        w_no_supp = w_rsvd ? ((o_reg_mask == 7'b0) && !o_hlt) : (i_instr[11:0] == 12'h000);
        o_illegal = !o_is_mem_ref && (!o_is_reg_ref || w_no_supp);
    end

endmodule

// File: rtl/control_sequencer.sv
// Basic-computer control sequencer: fetch, decode, indirect resolution and
// execute-strobe sequencing with datapath handshake and execute timeout.
module control_sequencer
    import cpu_pkg::*;
#(
    parameter int EXEC_TIMEOUT = 8,
    parameter int RESET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [DWIDTH-1:0] i_mem_data,
    input  logic              i_mem_ack,
    input  logic              i_ex_done,
    output logic              o_read,
    output logic              o_clr_reg,
    output logic              o_fetch,
    output logic              o_execute,
    output logic              o_is_ind,
    output logic              o_is_dir,
    output logic              o_add,
    output logic              o_load,
    output logic              o_store,
    output logic              o_branch,
    output logic              o_isz,
    output logic              o_clr_ac,
    output logic              o_clr_e,
    output logic              o_comp_ac,
    output logic              o_load_ac,
    output logic              o_cir_r,
    output logic              o_cir_l,
    output logic              o_inc_ac,
    output logic [DWIDTH-1:0] o_instr,
    output logic              o_halt,
    output logic              o_illegal,
    output logic              o_timeout
);

    localparam logic [7:0] INIT_LAST = 8'(RESET_CYCLES);
    localparam logic [7:0] TO_LAST   = 8'(EXEC_TIMEOUT - 1);

    state_t              r_state, w_nxt_state;
    logic [7:0]          r_init_cnt, w_nxt_init;
    logic [7:0]          r_tcnt, w_nxt_tcnt;
    logic [MASK_W-1:0]   r_mask, w_nxt_mask;
    logic                r_hlt, w_nxt_hlt;
    logic                r_gap, w_nxt_gap;
    logic [DWIDTH-1:0]   r_instr;
    logic                r_read, r_clr, r_fetch, r_exec, r_dir, r_halt, r_ill, r_tmo;
    logic [4:0]          r_mem_strb;
    logic [MASK_W-1:0]   r_reg_strb;
    logic                w_nxt_ill, w_nxt_tmo, w_strobe_on;

    logic                w_is_mem_ref, w_is_reg_ref, w_is_ind, w_hlt, w_illegal;
    logic [4:0]          w_op_onehot;
    logic [MASK_W-1:0]   w_reg_mask;

    ctrl_decode u_decode (
        .i_instr      (r_instr),
        .o_is_mem_ref (w_is_mem_ref),
        .o_is_reg_ref (w_is_reg_ref),
        .o_is_ind     (w_is_ind),
        .o_op_onehot  (w_op_onehot),
        .o_reg_mask   (w_reg_mask),
        .o_hlt        (w_hlt),
        .o_illegal    (w_illegal)
    );

    // Next-state, micro-op mask and counter logic
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_init  = r_init_cnt;
        w_nxt_tcnt  = 8'd0;
        w_nxt_mask  = r_mask;
        w_nxt_hlt   = r_hlt;
        w_nxt_gap   = 1'b0;
        w_nxt_ill   = 1'b0;
        w_nxt_tmo   = 1'b0;
        case (r_state)
            S_INIT: begin
                if (r_init_cnt == INIT_LAST) w_nxt_state = S_FETCH;
                else                         w_nxt_init  = r_init_cnt + 8'd1;
            end
            S_FETCH: begin
                if (i_mem_ack) w_nxt_state = S_DECODE;
                else           w_nxt_state = S_FETCH;
            end
            S_DECODE: begin
                w_nxt_mask = 7'b0;
                w_nxt_hlt  = 1'b0;
                if (w_is_mem_ref) begin
                    w_nxt_state = w_is_ind ? S_INDIRECT : S_EXEC;
                end else if (w_is_reg_ref && (w_reg_mask != 7'b0)) begin
                    w_nxt_state = S_EXEC;
                    w_nxt_mask  = w_reg_mask;
                    w_nxt_hlt   = w_hlt;
                end else if (w_hlt) begin
                    w_nxt_state = S_HALT;
                end else begin
                    w_nxt_state = S_FETCH;
                    w_nxt_ill   = w_illegal;
                end
            end
            S_INDIRECT: begin
                if (i_mem_ack) w_nxt_state = S_EXEC;
                else           w_nxt_state = S_INDIRECT;
            end
            S_EXEC: begin
                // Done beats a simultaneous timeout expiry; the gap cycle ignores done.
                if (r_gap) begin
                    w_nxt_state = S_EXEC;
                end else if (i_ex_done) begin
                    w_nxt_mask = r_mask & ~top_bit(r_mask);
                    if (w_nxt_mask != 7'b0) w_nxt_gap   = 1'b1;
                    else                    w_nxt_state = r_hlt ? S_HALT : S_FETCH;
                end else if (r_tcnt == TO_LAST) begin
                    w_nxt_tmo   = 1'b1;
                    w_nxt_mask  = 7'b0;
                    w_nxt_hlt   = 1'b0;
                    w_nxt_state = S_FETCH;
                end else begin
                    w_nxt_tcnt = r_tcnt + 8'd1;
                end
            end
            S_HALT: begin
                if (i_start) w_nxt_state = S_FETCH;
                else         w_nxt_state = S_HALT;
            end
            default: w_nxt_state = S_INIT;
        endcase
        w_strobe_on = (w_nxt_state == S_EXEC) && !w_nxt_gap;
    end

    // Control state and registered strobes
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_INIT;
            r_init_cnt <= 8'd0;
            r_tcnt     <= 8'd0;
            r_mask     <= 7'b0;
            r_hlt      <= 1'b0;
            r_gap      <= 1'b0;
            r_read     <= 1'b0;
            r_clr      <= 1'b0;
            r_fetch    <= 1'b0;
            r_exec     <= 1'b0;
            r_dir      <= 1'b0;
            r_halt     <= 1'b0;
            r_ill      <= 1'b0;
            r_tmo      <= 1'b0;
            r_mem_strb <= 5'b0;
            r_reg_strb <= 7'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_init_cnt <= w_nxt_init;
            r_tcnt     <= w_nxt_tcnt;
            r_mask     <= w_nxt_mask;
            r_hlt      <= w_nxt_hlt;
            r_gap      <= w_nxt_gap;
            r_read     <= (w_nxt_state == S_FETCH) || (w_nxt_state == S_INDIRECT);
            r_clr      <= (w_nxt_state == S_INIT);
            r_fetch    <= (w_nxt_state == S_FETCH);
            r_exec     <= (w_nxt_state == S_EXEC);
            r_dir      <= w_strobe_on && w_is_mem_ref;
            r_halt     <= (w_nxt_state == S_HALT);
            r_ill      <= w_nxt_ill;
            r_tmo      <= w_nxt_tmo;
            r_mem_strb <= w_strobe_on ? w_op_onehot : 5'b0;
            r_reg_strb <= w_strobe_on ? top_bit(w_nxt_mask) : 7'b0;
        end
    end

    // Instruction register: full word on fetch, address field on indirect
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_instr <= 16'h0000;
        end else if ((r_state == S_FETCH) && i_mem_ack) begin
            r_instr <= i_mem_data;
        end else if ((r_state == S_INDIRECT) && i_mem_ack) begin
            r_instr[AWIDTH-1:0] <= i_mem_data[AWIDTH-1:0];
        end else begin
            r_instr <= r_instr;
        end
    end

    assign o_is_ind  = (r_state == S_INDIRECT) && i_mem_ack;
    assign o_read    = r_read;
    assign o_clr_reg = r_clr;
    assign o_fetch   = r_fetch;
    assign o_execute = r_exec;
    assign o_is_dir  = r_dir;
    assign o_add     = r_mem_strb[0];
    assign o_load    = r_mem_strb[1];
    assign o_store   = r_mem_strb[2];
    assign o_branch  = r_mem_strb[3];
    assign o_isz     = r_mem_strb[4];
    assign o_clr_ac  = r_reg_strb[6];
    assign o_clr_e   = r_reg_strb[5];
    assign o_comp_ac = r_reg_strb[4];
    assign o_load_ac = r_reg_strb[3];
    assign o_cir_r   = r_reg_strb[2];
    assign o_cir_l   = r_reg_strb[1];
    assign o_inc_ac  = r_reg_strb[0];
    assign o_instr   = r_instr;
    assign o_halt    = r_halt;
    assign o_illegal = r_ill;
    assign o_timeout = r_tmo;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected output vectors
// written by hand for each instruction scenario.
module tb_control_sequencer;

    localparam logic [20:0] RD   = 21'h100000;
    localparam logic [20:0] CLR  = 21'h080000;
    localparam logic [20:0] FE   = 21'h040000;
    localparam logic [20:0] EX   = 21'h020000;
    localparam logic [20:0] IND  = 21'h010000;
    localparam logic [20:0] DIR  = 21'h008000;
    localparam logic [20:0] ADD  = 21'h004000;
    localparam logic [20:0] LDA  = 21'h002000;
    localparam logic [20:0] STA  = 21'h001000;
    localparam logic [20:0] CLA  = 21'h000200;
    localparam logic [20:0] INC  = 21'h000008;
    localparam logic [20:0] HLTO = 21'h000004;
    localparam logic [20:0] ILL  = 21'h000002;
    localparam logic [20:0] TMO  = 21'h000001;
    localparam logic [20:0] NONE = 21'h000000;

    logic        clk = 1'b0;
    logic        i_rst_n, i_start, i_mem_ack, i_ex_done;
    logic [15:0] i_mem_data;
    logic        o_read, o_clr_reg, o_fetch, o_execute, o_is_ind, o_is_dir;
    logic        o_add, o_load, o_store, o_branch, o_isz;
    logic        o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac;
    logic [15:0] o_instr;
    logic        o_halt, o_illegal, o_timeout;
    logic [20:0] w_st;

    int n_checks = 0;
    int n_errors = 0;

    control_sequencer #(.EXEC_TIMEOUT(8), .RESET_CYCLES(2)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_mem_data(i_mem_data),
        .i_mem_ack(i_mem_ack), .i_ex_done(i_ex_done), .o_read(o_read), .o_clr_reg(o_clr_reg),
        .o_fetch(o_fetch), .o_execute(o_execute), .o_is_ind(o_is_ind), .o_is_dir(o_is_dir),
        .o_add(o_add), .o_load(o_load), .o_store(o_store), .o_branch(o_branch), .o_isz(o_isz),
        .o_clr_ac(o_clr_ac), .o_clr_e(o_clr_e), .o_comp_ac(o_comp_ac), .o_load_ac(o_load_ac),
        .o_cir_r(o_cir_r), .o_cir_l(o_cir_l), .o_inc_ac(o_inc_ac), .o_instr(o_instr),
        .o_halt(o_halt), .o_illegal(o_illegal), .o_timeout(o_timeout)
    );

    always #5 clk = ~clk;

    assign w_st = {o_read, o_clr_reg, o_fetch, o_execute, o_is_ind, o_is_dir,
                   o_add, o_load, o_store, o_branch, o_isz,
                   o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
                   o_halt, o_illegal, o_timeout};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, check the output vector, advance to the next cycle point.
    task automatic cyc(input string tag, input logic ack, input logic [15:0] data,
                       input logic done, input logic start, input logic [20:0] exp);
        i_mem_ack  = ack;
        i_mem_data = data;
        i_ex_done  = done;
        i_start    = start;
        #1;
        check_eq(tag, {11'b0, w_st}, {11'b0, exp});
        @(posedge clk);
        #2;
        i_mem_ack = 1'b0;
        i_ex_done = 1'b0;
        i_start   = 1'b0;
    endtask

    initial begin
        i_rst_n = 1'b0; i_start = 1'b0; i_mem_ack = 1'b0; i_ex_done = 1'b0; i_mem_data = 16'h0000;
        @(posedge clk);
        #2;
        check_eq("reset_outputs", {11'b0, w_st}, 32'h0);
        check_eq("reset_instr", {16'b0, o_instr}, 32'h0);
        i_rst_n = 1'b1;

        cyc("init_c0", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        cyc("init_clr1", 1'b0, 16'h0000, 1'b0, 1'b0, CLR);
        cyc("init_clr2", 1'b0, 16'h0000, 1'b0, 1'b0, CLR);

        // LDA direct
        cyc("lda_fetch_wait", 1'b0, 16'h0000, 1'b0, 1'b0, RD | FE);
        cyc("lda_fetch_ack", 1'b1, 16'h2123, 1'b0, 1'b0, RD | FE);
        check_eq("lda_instr", {16'b0, o_instr}, 32'h2123);
        cyc("lda_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        cyc("lda_exec1", 1'b0, 16'h0000, 1'b0, 1'b1, EX | DIR | LDA);
        cyc("lda_exec2_stale_ack", 1'b1, 16'hFFFF, 1'b0, 1'b0, EX | DIR | LDA);
        cyc("lda_exec3", 1'b0, 16'h0000, 1'b0, 1'b0, EX | DIR | LDA);
        check_eq("lda_instr_kept", {16'b0, o_instr}, 32'h2123);
        cyc("lda_exec_done", 1'b0, 16'h0000, 1'b1, 1'b0, EX | DIR | LDA);

        // ADD indirect
        cyc("add_fetch_ack", 1'b1, 16'h9050, 1'b0, 1'b0, RD | FE);
        cyc("add_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        cyc("add_ind_wait", 1'b0, 16'h0000, 1'b0, 1'b0, RD);
        cyc("add_ind_ack", 1'b1, 16'h0ABC, 1'b0, 1'b0, RD | IND);
        check_eq("add_instr_ind", {16'b0, o_instr}, 32'h9ABC);
        cyc("add_exec1", 1'b0, 16'h0000, 1'b0, 1'b0, EX | DIR | ADD);
        cyc("add_exec_done", 1'b0, 16'h0000, 1'b1, 1'b0, EX | DIR | ADD);

        // CLA | INC | HLT
        cyc("reg_fetch_ack", 1'b1, 16'h7821, 1'b0, 1'b0, RD | FE);
        cyc("reg_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        cyc("reg_cla1", 1'b0, 16'h0000, 1'b0, 1'b0, EX | CLA);
        cyc("reg_cla_done", 1'b0, 16'h0000, 1'b1, 1'b0, EX | CLA);
        cyc("reg_gap", 1'b0, 16'h0000, 1'b0, 1'b0, EX);
        cyc("reg_inc_done", 1'b0, 16'h0000, 1'b1, 1'b0, EX | INC);
        cyc("reg_halt1", 1'b0, 16'h0000, 1'b0, 1'b0, HLTO);
        cyc("reg_halt_start", 1'b0, 16'h0000, 1'b0, 1'b1, HLTO);

        // STA with no done: timeout after 8 execute cycles
        cyc("sta_fetch_ack", 1'b1, 16'h3000, 1'b0, 1'b0, RD | FE);
        cyc("sta_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        for (int k = 1; k <= 8; k++) begin
            cyc($sformatf("sta_to_exec%0d", k), 1'b0, 16'h0000, 1'b0, 1'b0, EX | DIR | STA);
        end
        cyc("sta_timeout_pulse", 1'b0, 16'h0000, 1'b0, 1'b0, RD | FE | TMO);
        cyc("sta2_fetch_ack", 1'b1, 16'h3000, 1'b0, 1'b0, RD | FE);
        cyc("sta2_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        for (int k = 1; k <= 7; k++) begin
            cyc($sformatf("sta2_exec%0d", k), 1'b0, 16'h0000, 1'b0, 1'b0, EX | DIR | STA);
        end
        cyc("sta2_done_at_8", 1'b0, 16'h0000, 1'b1, 1'b0, EX | DIR | STA);
        cyc("sta2_no_timeout", 1'b0, 16'h0000, 1'b0, 1'b0, RD | FE);

        // Illegal op 0
        cyc("and_fetch_ack", 1'b1, 16'h0005, 1'b0, 1'b0, RD | FE);
        cyc("and_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        cyc("and_illegal", 1'b0, 16'h0000, 1'b0, 1'b0, RD | FE | ILL);

        // Reset during INDIRECT, stale ack after release
        cyc("rst_fetch_ack", 1'b1, 16'h9050, 1'b0, 1'b0, RD | FE);
        cyc("rst_decode", 1'b0, 16'h0000, 1'b0, 1'b0, NONE);
        cyc("rst_ind", 1'b0, 16'h0000, 1'b0, 1'b0, RD);
        i_rst_n   = 1'b0;
        i_mem_ack = 1'b1;
        #1;
        check_eq("rst_mid_outputs", {11'b0, w_st}, 32'h0);
        check_eq("rst_mid_instr", {16'b0, o_instr}, 32'h0);
        @(posedge clk);
        #2;
        i_rst_n = 1'b1;
        cyc("rst_stale_ack", 1'b1, 16'hFFFF, 1'b0, 1'b0, NONE);
        cyc("rst_clr1", 1'b0, 16'h0000, 1'b0, 1'b0, CLR);
        cyc("rst_clr2", 1'b0, 16'h0000, 1'b0, 1'b0, CLR);
        check_eq("rst_fetch", {11'b0, w_st}, {11'b0, RD | FE});
        check_eq("rst_instr_clean", {16'b0, o_instr}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
